// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and open-drain PS/2 line bundle for the host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  modport master (
    output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
    input  tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
  modport slave (
    input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
    output tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with clock inhibit, ACK check and timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input logic          clk,
  input logic          rst_n,
  ps2_host_tx_if.slave bus
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;
  state_t state, state_d;
  logic [1:0] clk_s, dat_s;
  logic [FW-1:0] f_cnt;
  logic filt, fall;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0] bitcnt, bitcnt_d;
  logic [7:0] sr, sr_d;
  logic par, par_d, ack_ok, ack_ok_d;
  logic clk_oe, clk_oe_d, data_oe, data_oe_d, done, done_d, err, err_d;
  logic fin;
  // fall strobes in the cycle the filtered clock takes its new low level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      f_cnt <= '0;
      filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], bus.ps2_clk_i};
      dat_s <= {dat_s[0], bus.ps2_data_i};
      fall <= 1'b0;
      if (clk_s[1] == filt) f_cnt <= '0;
      else if (f_cnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        f_cnt <= '0;
        fall <= filt;
      end else f_cnt <= f_cnt + FW'(1);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bitcnt <= '0;
      sr <= '0;
      par <= 1'b0;
      ack_ok <= 1'b0;
      clk_oe <= 1'b0;
      data_oe <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      bitcnt <= bitcnt_d;
      sr <= sr_d;
      par <= par_d;
      ack_ok <= ack_ok_d;
      clk_oe <= clk_oe_d;
      data_oe <= data_oe_d;
      done <= done_d;
      err <= err_d;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    bitcnt_d = bitcnt;
    sr_d = sr;
    par_d = par;
    ack_ok_d = ack_ok;
    clk_oe_d = clk_oe;
    data_oe_d = data_oe;
    done_d = 1'b0;
    err_d = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: if (bus.tx_valid) begin
        state_d = INHIBIT;
        cnt_d = '0;
        bitcnt_d = '0;
        sr_d = bus.tx_data;
        par_d = ~^bus.tx_data;
        clk_oe_d = 1'b1;
      end
      INHIBIT: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = SEND;
          cnt_d = '0;
          clk_oe_d = 1'b0;
          data_oe_d = 1'b1;
        end
      end
      SEND: if (fall) begin
        bitcnt_d = bitcnt + 4'd1;
        data_oe_d = bitcnt < 4'd8 ? ~sr[bitcnt[2:0]] : bitcnt == 4'd8 ? ~par : 1'b0;
        if (bitcnt == 4'd9) state_d = ACK;
      end
      ACK: if (fall) begin
        ack_ok_d = ~dat_s[1];
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (filt && dat_s[1]) begin
        fin = 1'b1;
        done_d = ack_ok;
        err_d = ~ack_ok;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // completion in the same cycle beats the timeout
    if (state inside {SEND, ACK, WAIT_IDLE}) begin
      cnt_d = cnt + CW'(1);
      if (cnt == CW'(TIMEOUT_CYCLES - 1) && !fin) begin
        state_d = IDLE;
        clk_oe_d = 1'b0;
        data_oe_d = 1'b0;
        err_d = 1'b1;
      end
    end
  end
  assign bus.tx_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.tx_done = done;
  assign bus.tx_err = err;
  assign bus.ps2_clk_oe = clk_oe;
  assign bus.ps2_data_oe = data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven frames against a wired-AND PS/2 device model, plus timeout,
// mid-frame reset and held-request/glitch sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TMO = 5000;
  localparam int H = 40;
  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic [10:0] bits;
    int          done;
    int          err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [10:0] obs;
  int inh, nd, ne, n, a0;
  vec_t v[4];
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.ps2_clk_i = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_i = dev_data & ~bus.ps2_data_oe;
  always @(posedge clk) if (rst_n && bus.tx_valid && bus.tx_ready) acc_cnt++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  // device: measures the inhibit, then clocks 11 times; line seen at release and rises 1..10
  task automatic run_dev(input logic ack, input int rst_at, input int glitch_at,
                         output logic [10:0] o, output int ih);
    int w;
    o = '0;
    ih = 0;
    w = 0;
    while (!bus.ps2_clk_oe && w < 50) begin
      tick(1);
      w++;
    end
    while (bus.ps2_clk_oe && ih < 4 * INH) begin
      tick(1);
      ih++;
    end
    o[0] = bus.ps2_data_i;
    tick(H);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == rst_at) begin
        check("pre_rst_data_oe", bus.ps2_data_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_clk_oe", bus.ps2_clk_oe, 0);
        check("rst_data_oe", bus.ps2_data_oe, 0);
        check("rst_ready", bus.tx_ready, 1);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        return;
      end
      tick(H);
      if (k <= 10) o[k] = bus.ps2_data_i;
      dev_clk = 1'b1;
      if (k == 10) dev_data = ack;
      if (k == 11) dev_data = 1'b1;
      if (k == glitch_at) begin
        tick(H / 2);
        dev_clk = 1'b0;
        tick(2);
        dev_clk = 1'b1;
        tick(H / 2 - 2);
      end else if (k < 11) tick(H);
    end
  endtask
  task automatic watch(input int k, output int d, output int e);
    d = 0;
    e = 0;
    repeat (k) begin
      tick(1);
      d += int'(bus.tx_done);
      e += int'(bus.tx_err);
    end
  endtask
  initial begin
    v[0] = '{8'hED, 1'b0, {2'b11, 8'hED, 1'b0}, 1, 0};
    v[1] = '{8'h00, 1'b0, {2'b11, 8'h00, 1'b0}, 1, 0};
    v[2] = '{8'h01, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1, 0};
    v[3] = '{8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 0, 1};
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    tick(3);
    check("reset_ready", bus.tx_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    check("reset_done_err", {bus.tx_done, bus.tx_err}, 0);
    rst_n = 1'b1;
    tick(20);
    for (int i = 0; i < 4; i++) begin
      bus.tx_data = v[i].data;
      bus.tx_valid = 1'b1;
      tick(1);
      bus.tx_valid = 1'b0;
      check("accept_busy", bus.busy, 1);
      run_dev(v[i].ack, 0, 0, obs, inh);
      check("inhibit_len", inh, INH);
      check("frame_bits", obs, v[i].bits);
      watch(60, nd, ne);
      check("done_pulses", nd, v[i].done);
      check("err_pulses", ne, v[i].err);
      check("end_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
      check("end_ready", bus.tx_ready, 1);
      tick(20);
    end
    // device never clocks: timeout measured from inhibit release
    bus.tx_data = 8'h55;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    n = 0;
    while (bus.ps2_clk_oe && n < 4 * INH) begin
      tick(1);
      n++;
    end
    check("start_bit_held", bus.ps2_data_oe, 1);
    n = 0;
    while (!bus.tx_err && n < TMO + 100) begin
      tick(1);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    check("timeout_ready", bus.tx_ready, 1);
    check("timeout_no_done", bus.tx_done, 0);
    tick(1);
    check("timeout_err_single", bus.tx_err, 0);
    tick(20);
    // reset at the 5th device fall, then a clean 0xF4 frame
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    run_dev(1'b0, 5, 0, obs, inh);
    watch(10, nd, ne);
    check("rst_no_pulse", nd + ne, 0);
    check("rst_idle", bus.busy, 0);
    rst_n = 1'b1;
    tick(20);
    bus.tx_data = 8'hF4;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    run_dev(1'b0, 0, 0, obs, inh);
    check("f4_bits", obs, {1'b1, 1'b0, 8'hF4, 1'b0});
    watch(60, nd, ne);
    check("f4_done", nd, 1);
    check("f4_err", ne, 0);
    tick(20);
    // tx_valid held with 0xFF, 2-cycle clock glitch after the 3rd rise
    a0 = acc_cnt;
    bus.tx_data = 8'hFF;
    bus.tx_valid = 1'b1;
    run_dev(1'b0, 0, 3, obs, inh);
    check("hold_inhibit_len", inh, INH);
    check("glitch_bits", obs, {2'b11, 8'hFF, 1'b0});
    check("hold_one_accept", acc_cnt - a0, 1);
    n = 0;
    while (!bus.tx_done && n < 100) begin
      tick(1);
      n++;
    end
    check("hold_done", bus.tx_done, 1);
    check("hold_ready_at_done", bus.tx_ready, 1);
    tick(1);
    check("hold_reaccept", bus.ps2_clk_oe, 1);
    check("hold_two_accepts", acc_cnt - a0, 2);
    bus.tx_valid = 1'b0;
    run_dev(1'b0, 0, 0, obs, inh);
    check("second_inhibit_len", inh, INH);
    check("second_bits", obs, {2'b11, 8'hFF, 1'b0});
    watch(60, nd, ne);
    check("second_done", nd, 1);
    check("second_err", ne, 0);
    check("total_accepts", acc_cnt - a0, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
